// File: rtl/fac_pkg.sv
// Shared definitions for the factorial slave register map and the host sequencer FSM.
package fac_pkg;

   localparam logic [7:0] ADDR_OPERAND  = 8'h00;
   localparam logic [7:0] ADDR_OPSTART  = 8'h08;
   localparam logic [7:0] ADDR_OPCLEAR  = 8'h10;
   localparam logic [7:0] ADDR_OPDONE   = 8'h18;
   localparam logic [7:0] ADDR_RESULT_H = 8'h20;
   localparam logic [7:0] ADDR_RESULT_L = 8'h28;

   // OPSTART, OPCLEAR and OPDONE all carry their flag in this bit.
   localparam int CTRL_BIT = 0;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WR_OP     = 4'd1,
      WR_START1 = 4'd2,
      WR_START0 = 4'd3,
      POLL_RD   = 4'd4,
      POLL_WAIT = 4'd5,
      GAP       = 4'd6,
      RD_HI     = 4'd7,
      RD_LO     = 4'd8,
      WR_CLR1   = 4'd9,
      WR_CLR0   = 4'd10,
      RESP      = 4'd11
   } host_state_t;

   function automatic logic [63:0] ctrl_word(input logic flag);
      logic [63:0] w;
      w           = '0;
      w[CTRL_BIT] = flag;
      return w;
   endfunction

endpackage

// File: rtl/fac_bus_port.sv
// Master-side bus port: holds one request until granted and flags the read-data cycle.
module fac_bus_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        wr,
   input  logic [7:0]  addr,
   input  logic [63:0] data,
   output logic        done,
   output logic        rvalid,
   output logic [63:0] rdata,
   output logic        M_req,
   output logic        M_wr,
   output logic [7:0]  M_address,
   output logic [63:0] M_dout,
   input  logic        M_grant,
   input  logic [63:0] M_din
);

   assign done  = M_req & M_grant;
   assign rdata = M_din;

   // A new start on the grant edge keeps M_req high so transfers run back to back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         M_req     <= 1'b0;
         M_wr      <= 1'b0;
         M_address <= '0;
         M_dout    <= '0;
         rvalid    <= 1'b0;
      end else begin
         if (start) begin
            M_req     <= 1'b1;
            M_wr      <= wr;
            M_address <= addr;
            M_dout    <= data;
         end else if (done) begin
            M_req <= 1'b0;
         end
         rvalid <= done & ~M_wr;
      end
   end

endmodule

// File: rtl/fac_host.sv
// Bus-master sequencer driving the factorial slave: write operand, pulse start, poll, read, clear.
// Optional FAC_HOST_TIMEOUT_EN bounds polling to TIMEOUT_POLLS reads and reports an aborted job.
module fac_host
   import fac_pkg::*;
#(
   parameter int POLL_GAP      = 4,
   parameter int TIMEOUT_POLLS = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [63:0]  cmd_n,
   output logic         rsp_valid,
   output logic [127:0] rsp_result,
   output logic         rsp_timeout,
   output logic         M_req,
   output logic         M_wr,
   output logic [7:0]   M_address,
   output logic [63:0]  M_dout,
   input  logic         M_grant,
   input  logic [63:0]  M_din
);

   localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

   host_state_t state, state_next;
   logic [63:0] n_reg;
   logic [63:0] res_hi, res_lo;
   logic [7:0]  gap_cnt;
   logic        start, req_wr;
   logic [7:0]  req_addr;
   logic [63:0] req_data;
   logic        done, rvalid;
   logic [63:0] rdata;
   logic        poll_limit, timed_out;

   fac_bus_port u_port (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .wr        (req_wr),
      .addr      (req_addr),
      .data      (req_data),
      .done      (done),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .M_req     (M_req),
      .M_wr      (M_wr),
      .M_address (M_address),
      .M_dout    (M_dout),
      .M_grant   (M_grant),
      .M_din     (M_din)
   );

   // Each state hands the next transfer to the port on the edge its own transfer completes.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      req_wr     = 1'b0;
      req_addr   = ADDR_OPERAND;
      req_data   = '0;
      case (state)
         IDLE: if (cmd_valid) state_next = WR_OP;
         WR_OP: begin
            if (!M_req) begin
               start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPERAND; req_data = n_reg;
            end else if (done) begin
               state_next = WR_START1;
               start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPSTART; req_data = ctrl_word(1'b1);
            end
         end
         WR_START1: if (done) begin
            state_next = WR_START0;
            start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPSTART; req_data = ctrl_word(1'b0);
         end
         WR_START0: if (done) begin
            state_next = POLL_RD;
            start = 1'b1; req_addr = ADDR_OPDONE;
         end
         POLL_RD: if (done) state_next = POLL_WAIT;
         POLL_WAIT: if (rvalid) begin
            if (rdata[CTRL_BIT]) begin
               state_next = RD_HI;
               start = 1'b1; req_addr = ADDR_RESULT_H;
            end else if (poll_limit) begin
               state_next = WR_CLR1;
               start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPCLEAR; req_data = ctrl_word(1'b1);
            end else if (POLL_GAP == 0) begin
               state_next = POLL_RD;
               start = 1'b1; req_addr = ADDR_OPDONE;
            end else begin
               state_next = GAP;
            end
         end
         GAP: if (gap_cnt == GAP_LAST) begin
            state_next = POLL_RD;
            start = 1'b1; req_addr = ADDR_OPDONE;
         end
         RD_HI: if (rvalid) begin
            state_next = RD_LO;
            start = 1'b1; req_addr = ADDR_RESULT_L;
         end
         RD_LO: if (rvalid) begin
            state_next = WR_CLR1;
            start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPCLEAR; req_data = ctrl_word(1'b1);
         end
         WR_CLR1: if (done) begin
            state_next = WR_CLR0;
            start = 1'b1; req_wr = 1'b1; req_addr = ADDR_OPCLEAR; req_data = ctrl_word(1'b0);
         end
         WR_CLR0: if (done) state_next = RESP;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_timeout <= 1'b0;
         n_reg       <= '0;
         res_hi      <= '0;
         res_lo      <= '0;
         gap_cnt     <= '0;
      end else begin
         state     <= state_next;
         cmd_ready <= (state_next == IDLE);
         rsp_valid <= (state_next == RESP);
         gap_cnt   <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
         if (state == IDLE && cmd_valid) n_reg <= cmd_n;
         if (state == RD_HI && rvalid) res_hi <= rdata;
         if (state == RD_LO && rvalid) res_lo <= rdata;
         if (state_next == RESP) begin
            rsp_result  <= timed_out ? 128'd0 : {res_hi, res_lo};
            rsp_timeout <= timed_out;
         end
      end
   end

`ifdef FAC_HOST_TIMEOUT_EN
   logic [15:0] poll_cnt;

   assign poll_limit = (poll_cnt >= 16'(TIMEOUT_POLLS));

   // Counts accepted OPDONE reads; the abort decision latches until the next job starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         poll_cnt  <= '0;
         timed_out <= 1'b0;
      end else if (state == IDLE && cmd_valid) begin
         poll_cnt  <= '0;
         timed_out <= 1'b0;
      end else begin
         if (state == POLL_RD && done) poll_cnt <= poll_cnt + 16'd1;
         if (state == POLL_WAIT && rvalid && !rdata[CTRL_BIT] && poll_limit) timed_out <= 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_POLLS != 0);
   assign poll_limit     = 1'b0;
   assign timed_out      = 1'b0;
`endif

endmodule

// File: doc/fac_host.md
# fac_host

Bus-master sequencer that drives the factorial computation slave from the initiator side. It accepts one operand from a local command port, then issues the slave's register writes: operand, opstart pulse, opclear pulse. It polls opdone, reads back the 128-bit result and returns it on a response port. It sits between a host/testbench command source and the shared single-master register bus in front of the factorial core.

## Interface
- POLL_GAP, default 4: idle cycles between consecutive opdone polls (0..255).
- TIMEOUT_POLLS, default 1024: polls issued before abort (only with FAC_HOST_TIMEOUT_EN).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_n  in  64  operand N.
- rsp_valid  out  1  one-cycle pulse: result available.
- rsp_result  out  128  {RESULT_H, RESULT_L}.
- rsp_timeout  out  1  qualifies rsp_valid: job aborted (0 when macro absent).
- M_req  out  1  bus request; held until granted.
- M_wr  out  1  1 = write, 0 = read.
- M_address  out  8  register byte address.
- M_dout  out  64  write data.
- M_grant  in  1  transfer accepted this cycle when M_req & M_grant.
- M_din  in  64  read data, valid the cycle after an accepted read.

## Operation
- Register map (byte addresses): OPERAND 0x00, OPSTART 0x08, OPCLEAR 0x10, OPDONE 0x18, RESULT_H 0x20, RESULT_L 0x28. Only bit 0 is meaningful in OPSTART, OPCLEAR and OPDONE.
- FSM states: IDLE, WR_OP, WR_START1, WR_START0, POLL_RD, POLL_WAIT, GAP, RD_HI, RD_LO, WR_CLR1, WR_CLR0, RESP.
- IDLE: if cmd_valid, latch cmd_n and go to WR_OP.
- WR_OP: write cmd_n to OPERAND.
- WR_START1 / WR_START0: write 1, then 0, to OPSTART. The slave leaves its offset state only when opstart[0] returns to 0.
- POLL_RD: issue a read of OPDONE.
- POLL_WAIT: sample M_din[0].
  - 1 → RD_HI.
  - 0 → GAP, which counts POLL_GAP cycles, then returns to POLL_RD.
- RD_HI / RD_LO: read RESULT_H, then RESULT_L. Each read has a wait cycle for data; capture into the result register.
- WR_CLR1 / WR_CLR0: write 1, then 0, to OPCLEAR. The slave returns to INIT on 1 and re-arms on 0.
- RESP: rsp_valid = 1 for one cycle, then go to IDLE.
- Bus handshake: in any bus state, hold M_req/M_wr/M_address/M_dout stable until a cycle with M_grant = 1. Advance on that edge. An ungranted cycle advances nothing.
- At most one outstanding transaction; M_req is low in IDLE, GAP, POLL_WAIT, read-wait cycles and RESP.
- cmd_valid while busy: ignored (cmd_ready = 0); no queuing.
- M_din is ignored outside read-wait cycles.

## Timing
- All outputs are registered.
- Reset values: state IDLE; cmd_ready 1; rsp_valid 0; rsp_timeout 0; rsp_result 0; M_req 0; M_wr 0; M_address 0; M_dout 0; poll/gap counters 0.
- Reset asserted mid-job: return to IDLE immediately with no bus cleanup. The next job's WR_OP…WR_CLR sequence re-synchronises the slave.
- Latency with M_grant tied high and opdone already set:
  - cmd accept → first write: 1 cycle.
  - 3 writes: 3 cycles.
  - first poll: 2 cycles.
  - 2 reads: 4 cycles.
  - 2 clear writes: 2 cycles.
  - RESP: 1 cycle.
  - rsp_valid is asserted 13 cycles after the accept edge.
- Each extra failed poll adds 2 + POLL_GAP cycles.
- rsp_result holds its value until the next RESP.

## Configuration
- FAC_HOST_TIMEOUT_EN defined:
  - 16-bit poll counter, cleared on entry to WR_OP and incremented per issued OPDONE read.
  - When it reaches TIMEOUT_POLLS with opdone still 0, skip the reads and go to WR_CLR1.
  - RESP then pulses rsp_valid with rsp_timeout = 1 and rsp_result = 0.
- Undefined: no counter; polling is unbounded; rsp_timeout is tied 0.

## Structure
- Package fac_pkg holds:
  - the register address constants (ADDR_OPERAND … ADDR_RESULT_L);
  - the host FSM state enum (4-bit encoding);
  - the shared bit-0 field constant for OPSTART/OPCLEAR/OPDONE, reused by the slave side.
- One natural sub-module, fac_bus_port: owns the M_req hold-until-grant register set and the read-data capture strobe. The FSM only requests {wr, addr, data} and receives done/rdata.

## Test plan
- N=5, M_grant tied 1, slave model asserts opdone after 2 polls, POLL_GAP=4 → bus trace: writes 0x00=5, 0x08=1, 0x08=0; 3 reads of 0x18; reads 0x20, 0x28; writes 0x10=1, 0x10=0; rsp_result=120.
- M_grant low for 3 cycles on every transfer → address/data stable across stalls; result is still correct; total cycles grow by 3 per transfer.
- opdone already 1 at first poll, N=20 → rsp_valid 13 cycles after accept; rsp_result=0x0000…21C3677C82B40000.
- cmd_valid held high through a job → exactly one job accepted; second accept only after RESP, when cmd_ready = 1.
- reset pulsed during POLL_WAIT → all outputs return to reset values on the same edge; a new N=3 job then completes with result 6.
- FAC_HOST_TIMEOUT_EN, TIMEOUT_POLLS=8, opdone stuck 0 → 8 OPDONE reads, clear writes issued, rsp_valid with rsp_timeout=1 and rsp_result=0.
